// File: rtl/alu_seq_if.sv
// Handshake bundle between the register-file read stage and alu_seq.
// The master side drives operands/op and consumes results; the slave side is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [2:0]       status;

  modport master (
    output in_valid, op, ain, bin, out_ready,
    input  in_ready, out_valid, out, status
  );

  modport slave (
    input  in_valid, op, ain, bin, out_ready,
    output in_ready, out_valid, out, status
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked, registered ALU with {N,V,Z} status and an optional shift-add multiplier.
// Optional feature macro: ALU_SEQ_MUL_EN. When defined, op 111 runs a WIDTH-cycle
// shift-add multiply through the BUSY state; when undefined, op 111 completes in one
// cycle with out=0 and status left unchanged.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);

  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;

`ifdef ALU_SEQ_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b111;
  localparam int         CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_e;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] out_q;
  logic [2:0]       status_q;
  logic             outValid_q;

  logic [WIDTH-1:0] result_d;
  logic [2:0]       status_d;
  logic             inReady;
  logic             accept;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] mulAcc_d;
`endif

  // A new op can enter when idle, or when the held result is being taken this cycle.
  assign inReady = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign accept  = bus.in_valid & inReady;

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid_q;
  assign bus.out       = out_q;
  assign bus.status    = status_q;

  // Single-cycle result and flag update for the presented operands; logic ops keep old flags.
  always_comb begin
    result_d = '0;
    status_d = status_q;
    case (bus.op)
      OP_ADD: begin
        result_d = bus.ain + bus.bin;
        status_d = {result_d[MSB],
                    (bus.ain[MSB] == bus.bin[MSB]) & (result_d[MSB] != bus.ain[MSB]),
                    result_d == '0};
      end
      OP_SUB, OP_CMP: begin
        result_d = bus.ain - bus.bin;
        status_d = {result_d[MSB],
                    (bus.ain[MSB] != bus.bin[MSB]) & (result_d[MSB] != bus.ain[MSB]),
                    result_d == '0};
      end
      OP_AND: result_d = bus.ain & bus.bin;
      OP_NOT: result_d = ~bus.bin;
      OP_OR:  result_d = bus.ain | bus.bin;
      OP_XOR: result_d = bus.ain ^ bus.bin;
      default: begin
        result_d = '0;
        status_d = status_q;
      end
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  // Accumulator value after this BUSY iteration: add the shifted multiplicand when the multiplier LSB is set.
  always_comb begin
    mulAcc_d = acc_q;
    if (mplier_q[0]) begin
      mulAcc_d = acc_q + mcand_q;
    end
  end
`endif

  // Control FSM with registered result, status and out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      out_q      <= '0;
      status_q   <= 3'b000;
      outValid_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
`ifdef ALU_SEQ_MUL_EN
            if (bus.op == OP_MUL) begin
              state_q    <= BUSY;
              outValid_q <= 1'b0;
              mcand_q    <= {{WIDTH{1'b0}}, bus.ain};
              mplier_q   <= bus.bin;
              acc_q      <= '0;
              cnt_q      <= '0;
            end else
`endif
            begin
              state_q    <= DONE;
              outValid_q <= 1'b1;
              out_q      <= result_d;
              status_q   <= status_d;
            end
          end else if ((state_q == DONE) && bus.out_ready) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        BUSY: begin
          if (cnt_q == CNT_LAST) begin
            state_q    <= DONE;
            outValid_q <= 1'b1;
            acc_q      <= mulAcc_d;
            out_q      <= mulAcc_d[MSB:0];
            status_q   <= {mulAcc_d[MSB],
                           |mulAcc_d[2*WIDTH-1:WIDTH],
                           mulAcc_d[MSB:0] == '0};
          end else begin
            acc_q    <= mulAcc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_q    <= IDLE;
          outValid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed steps followed by randomized ops,
// compared against an arithmetic reference model of the ALU rules.
module tb_alu_seq;

  localparam int W = 16;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [2:0]   expStatus;
  logic [W-1:0] gotOut;
  logic [2:0]   gotSt;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  // Reference model from the arithmetic rules: signed range test for V, full product for MUL.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b, inout logic [2:0] st);
    int sa, sb, sr;
    longint prod;
    logic [W-1:0] r;
    logic v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = '0;
    case (o)
      3'd0: begin
        sr = sa + sb;
        r  = W'(sr);
        v  = (sr > 32767) || (sr < -32768);
        st = {r >= 16'h8000, v, r == 0};
      end
      3'd1, 3'd6: begin
        sr = sa - sb;
        r  = W'(sr);
        v  = (sr > 32767) || (sr < -32768);
        st = {r >= 16'h8000, v, r == 0};
      end
      3'd2: r = a & b;
      3'd3: r = ~b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      default: begin
        if (MUL_EN) begin
          prod = longint'(a) * longint'(b);
          r    = W'(prod % 65536);
          st   = {r >= 16'h8000, (prod / 65536) != 0, r == 0};
        end else begin
          r = '0;
        end
      end
    endcase
    return r;
  endfunction

  // Issue one op with out_ready=1, check busy window, latency and result against the model.
  task automatic runOp(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, output logic [W-1:0] oOut, output logic [2:0] oSt);
    logic [W-1:0] expOut;
    int lat;
    bus.in_valid  = 1'b1;
    bus.op        = o;
    bus.ain       = a;
    bus.bin       = b;
    bus.out_ready = 1'b1;
    #1;
    check({tag, "_inready"}, 32'(bus.in_ready), 32'd1);
    expOut = model(o, a, b, expStatus);
    lat = (MUL_EN && o == 3'd7) ? W + 1 : 1;
    @(posedge clk); #1;
    for (int k = 1; k < lat; k++) begin
      check({tag, "_busy"}, 32'({bus.out_valid, bus.in_ready}), 32'd0);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.op       = 3'($urandom_range(0, 7));
      bus.ain      = W'($urandom);
      bus.bin      = W'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_out"}, 32'(bus.out), 32'(expOut));
    check({tag, "_status"}, 32'(bus.status), 32'(expStatus));
    oOut = bus.out;
    oSt  = bus.status;
  endtask

  // Directed and randomized stimulus.
  initial begin
    checks        = 0;
    failures      = 0;
    expStatus     = 3'b000;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.ain       = '0;
    bus.bin       = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_status", 32'(bus.status), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_inready", 32'(bus.in_ready), 32'd1);

    // Signed overflow on ADD.
    runOp("add_ovf", 3'd0, 16'h7FFF, 16'h0001, gotOut, gotSt);
    check("add_ovf_lit_out", 32'(gotOut), 32'h8000);
    check("add_ovf_lit_st", 32'(gotSt), 32'b110);

    // CMP equal sets Z; AND keeps flags.
    runOp("cmp_eq", 3'd6, 16'h0005, 16'h0005, gotOut, gotSt);
    check("cmp_eq_lit_out", 32'(gotOut), 32'h0000);
    check("cmp_eq_lit_st", 32'(gotSt), 32'b001);
    runOp("and", 3'd2, 16'hF0F0, 16'h0FF0, gotOut, gotSt);
    check("and_lit_out", 32'(gotOut), 32'h00F0);
    check("and_lit_st", 32'(gotSt), 32'b001);

    // CMP signed overflow; NOT keeps flags.
    runOp("cmp_ovf", 3'd6, 16'h8000, 16'h0001, gotOut, gotSt);
    check("cmp_ovf_lit_out", 32'(gotOut), 32'h7FFF);
    check("cmp_ovf_lit_st", 32'(gotSt), 32'b010);
    runOp("not", 3'd3, 16'h1234, 16'h00FF, gotOut, gotSt);
    check("not_lit_out", 32'(gotOut), 32'hFF00);
    check("not_lit_st", 32'(gotSt), 32'b010);

    // Multiply, including a product that overflows the low half.
    runOp("mul_a", 3'd7, 16'd300, 16'd200, gotOut, gotSt);
    runOp("mul_b", 3'd7, 16'h0100, 16'h0100, gotOut, gotSt);
`ifdef ALU_SEQ_MUL_EN
    check("mul_b_lit_out", 32'(gotOut), 32'h0000);
    check("mul_b_lit_st", 32'(gotSt), 32'b011);
`else
    check("mul_b_lit_out", 32'(gotOut), 32'h0000);
    check("mul_b_lit_st", 32'(gotSt), 32'b010);
`endif

    // Drain to IDLE.
    @(posedge clk); #1;
    check("drain_valid", 32'(bus.out_valid), 32'd0);

    // Back-pressure: ADD result held while a SUB waits.
    bus.in_valid  = 1'b1;
    bus.op        = 3'd0;
    bus.ain       = 16'd1;
    bus.bin       = 16'd2;
    bus.out_ready = 1'b0;
    gotOut = model(3'd0, 16'd1, 16'd2, expStatus);
    @(posedge clk); #1;
    bus.op  = 3'd1;
    bus.ain = 16'd9;
    bus.bin = 16'd4;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_out", 32'(bus.out), 32'h0003);
      check("bp_hold_ready", 32'({bus.out_valid, bus.in_ready}), 32'b10);
      @(posedge clk); #1;
    end
    check("bp_hold_status", 32'(bus.status), 32'(expStatus));
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    gotOut = model(3'd1, 16'd9, 16'd4, expStatus);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_sub_out", 32'(bus.out), 32'h0005);
    check("bp_sub_status", 32'({bus.out_valid, bus.status}), 32'({1'b1, expStatus}));

    // Randomized back-to-back ops.
    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? ra : W'($urandom);
      if ($urandom_range(0, 4) == 0) ra = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
      runOp("rnd", 3'($urandom_range(0, 7)), ra, rb, gotOut, gotSt);
    end

    // Reset in the middle of a multiply.
    bus.in_valid  = 1'b1;
    bus.op        = 3'd7;
    bus.ain       = 16'h1234;
    bus.bin       = 16'h0002;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(bus.out), 32'd0);
    check("midrst_status", 32'(bus.status), 32'd0);
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    expStatus = 3'b000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    runOp("post_rst_add", 3'd0, 16'd1, 16'd1, gotOut, gotSt);
    check("post_rst_lit_out", 32'(gotOut), 32'h0002);

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
